// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: stall/flush controller on the consuming (EXE) side of the REG/EXE register.
//
// Compares the EXE-stage destination with the REG-stage sources to detect load-use hazards,
// and sequences multi-cycle load-use stalls, data-memory wait freezes and branch flushes.
// Priority within a cycle: memory wait > branch flush > load-use.
//
// Parameters:
//   LOAD_LAT  bubble cycles inserted per load-use hazard (1..7)
//   CNT_W     stall counter width, must hold LOAD_LAT
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   id_ra_i, id_rb_i    REG-stage source registers; id_use_ra_i/id_use_rb_i mark them as read
//   exe_rd_i            EXE-stage destination; exe_is_load_i, exe_valid_i qualify it
//   br_taken_i          EXE resolved a taken branch
//   mem_req_i/ack_i     outstanding data-memory access / completion
//   pc_hold_o, ifid_hold_o, regexe_hold_o   freeze PC, IF/ID, REG/EXE
//   bubble_o            force ctrl = 0 into REG/EXE; ifid_flush_o clears IF/ID
//   busy_o              FSM is not idle
//
// Optional feature (macro HAZARD_STATS_EN): adds saturating 16-bit counters
//   stall_cnt_o (cycles with pc_hold_o) and flush_cnt_o (cycles with ifid_flush_o).

module hazard_stall_ctrl #(
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] id_ra_i,
    input  logic [3:0] id_rb_i,
    input  logic       id_use_ra_i,
    input  logic       id_use_rb_i,
    input  logic [3:0] exe_rd_i,
    input  logic       exe_is_load_i,
    input  logic       exe_valid_i,
    input  logic       br_taken_i,
    input  logic       mem_req_i,
    input  logic       mem_ack_i,
    output logic       pc_hold_o,
    output logic       ifid_hold_o,
    output logic       regexe_hold_o,
    output logic       bubble_o,
    output logic       ifid_flush_o,
    output logic       busy_o
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o
`endif
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StLdStall = 2'd1;
    localparam logic [1:0] StMemWait = 2'd2;
    localparam logic [1:0] StFlush   = 2'd3;

    localparam logic [CNT_W-1:0] LdInit = CNT_W'(LOAD_LAT - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Set when a memory wait interrupts the second flush slot, so it is re-issued afterwards.
    logic             flush_pend_q, flush_pend_d;

    logic hz_ld, mem_wait;
    logic pc_hold, ifid_hold, regexe_hold, bubble, ifid_flush;

    assign hz_ld = exe_valid_i & exe_is_load_i &
                   ((id_use_ra_i & (id_ra_i == exe_rd_i)) |
                    (id_use_rb_i & (id_rb_i == exe_rd_i)));
    assign mem_wait = mem_req_i & ~mem_ack_i;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        pc_hold      = 1'b0;
        ifid_hold    = 1'b0;
        regexe_hold  = 1'b0;
        bubble       = 1'b0;
        ifid_flush   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_wait) begin
                    {pc_hold, ifid_hold, regexe_hold} = 3'b111;
                    state_d = StMemWait;
                end else if (br_taken_i) begin
                    // Any concurrent hz_ld belongs to a wrong-path instruction.
                    ifid_flush = 1'b1;
                    bubble     = 1'b1;
                    state_d    = StFlush;
                end else if (hz_ld) begin
                    {pc_hold, ifid_hold, bubble} = 3'b111;
                    if (LOAD_LAT > 1) begin
                        state_d = StLdStall;
                        cnt_d   = LdInit;
                    end
                end
            end
            StLdStall: begin
                if (mem_wait) begin
                    // Freeze with cnt preserved; remaining bubbles resume after the wait.
                    {pc_hold, ifid_hold, regexe_hold} = 3'b111;
                    state_d = StMemWait;
                end else begin
                    {pc_hold, ifid_hold, bubble} = 3'b111;
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            StMemWait: begin
                if (mem_ack_i) begin
                    flush_pend_d = 1'b0;
                    if (flush_pend_q) begin
                        state_d = StFlush;
                    end else if (cnt_q != '0) begin
                        state_d = StLdStall;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    {pc_hold, ifid_hold, regexe_hold} = 3'b111;
                end
            end
            StFlush: begin
                if (mem_wait) begin
                    {pc_hold, ifid_hold, regexe_hold} = 3'b111;
                    flush_pend_d = 1'b1;
                    state_d      = StMemWait;
                end else begin
                    ifid_flush = 1'b1;
                    bubble     = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Outputs are forced low while reset is asserted, even with hazard inputs present.
    assign pc_hold_o     = pc_hold & rst_n;
    assign ifid_hold_o   = ifid_hold & rst_n;
    assign regexe_hold_o = regexe_hold & rst_n;
    assign bubble_o      = bubble & rst_n;
    assign ifid_flush_o  = ifid_flush & rst_n;
    assign busy_o        = (state_q != StIdle) & rst_n;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pc_hold && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (ifid_flush && flush_cnt_q != 16'hFFFF) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl. Two instances (LOAD_LAT=1 and LOAD_LAT=3) share stimulus.
// Output vectors are packed as {pc_hold, ifid_hold, regexe_hold, bubble, ifid_flush, busy}.

module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] id_ra, id_rb, exe_rd;
    logic       id_use_ra, id_use_rb, exe_is_load, exe_valid, br_taken, mem_req, mem_ack;

    logic pc1, ifid1, rex1, bub1, fl1, busy1;
    logic pc3, ifid3, rex3, bub3, fl3, busy3;
    logic [5:0] o1, o3;

    int vectors = 0;
    int miscompares = 0;

`ifdef HAZARD_STATS_EN
    logic [15:0] st1, fc1, st3, fc3;
`endif

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.LOAD_LAT(1), .CNT_W(3)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .id_ra_i(id_ra), .id_rb_i(id_rb), .id_use_ra_i(id_use_ra), .id_use_rb_i(id_use_rb),
        .exe_rd_i(exe_rd), .exe_is_load_i(exe_is_load), .exe_valid_i(exe_valid),
        .br_taken_i(br_taken), .mem_req_i(mem_req), .mem_ack_i(mem_ack),
        .pc_hold_o(pc1), .ifid_hold_o(ifid1), .regexe_hold_o(rex1), .bubble_o(bub1),
        .ifid_flush_o(fl1), .busy_o(busy1)
`ifdef HAZARD_STATS_EN
        , .stall_cnt_o(st1), .flush_cnt_o(fc1)
`endif
    );

    hazard_stall_ctrl #(.LOAD_LAT(3), .CNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .id_ra_i(id_ra), .id_rb_i(id_rb), .id_use_ra_i(id_use_ra), .id_use_rb_i(id_use_rb),
        .exe_rd_i(exe_rd), .exe_is_load_i(exe_is_load), .exe_valid_i(exe_valid),
        .br_taken_i(br_taken), .mem_req_i(mem_req), .mem_ack_i(mem_ack),
        .pc_hold_o(pc3), .ifid_hold_o(ifid3), .regexe_hold_o(rex3), .bubble_o(bub3),
        .ifid_flush_o(fl3), .busy_o(busy3)
`ifdef HAZARD_STATS_EN
        , .stall_cnt_o(st3), .flush_cnt_o(fc3)
`endif
    );

    assign o1 = {pc1, ifid1, rex1, bub1, fl1, busy1};
    assign o3 = {pc3, ifid3, rex3, bub3, fl3, busy3};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_ra = 4'h0; id_rb = 4'h0; exe_rd = 4'h0;
        id_use_ra = 1'b0; id_use_rb = 1'b0; exe_is_load = 1'b0; exe_valid = 1'b0;
        br_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic settle();
        clear_inputs();
        repeat (5) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        // Hazard present during reset: outputs must still be low.
        exe_valid = 1'b1; exe_is_load = 1'b1; exe_rd = 4'h3; id_ra = 4'h3; id_use_ra = 1'b1;
        br_taken = 1'b1; mem_req = 1'b1;
        #12;
        vectors++;
        if (o1 !== 6'b000000) begin
            miscompares++; $display("FAIL reset_dut1 got %b exp %b", o1, 6'b000000);
        end
        vectors++;
        if (o3 !== 6'b000000) begin
            miscompares++; $display("FAIL reset_dut3 got %b exp %b", o3, 6'b000000);
        end
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_use_lat1();
        exe_valid = 1'b1; exe_is_load = 1'b1; exe_rd = 4'h3; id_ra = 4'h3; id_use_ra = 1'b1;
        @(negedge clk);
        vectors++;
        if (o1 !== 6'b110100) begin
            miscompares++; $display("FAIL ld1_c0 got %b exp %b", o1, 6'b110100);
        end
        tick();
        exe_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (o1 !== 6'b000000) begin
            miscompares++; $display("FAIL ld1_c1 got %b exp %b", o1, 6'b000000);
        end
        settle();
        // No zero-register exemption: r0 still hazards.
        exe_valid = 1'b1; exe_is_load = 1'b1; exe_rd = 4'h0; id_rb = 4'h0; id_use_rb = 1'b1;
        @(negedge clk);
        vectors++;
        if (o1 !== 6'b110100) begin
            miscompares++; $display("FAIL ld1_r0 got %b exp %b", o1, 6'b110100);
        end
        settle();
        // Non-load producer: no stall.
        exe_valid = 1'b1; exe_is_load = 1'b0; exe_rd = 4'h7; id_ra = 4'h7; id_use_ra = 1'b1;
        @(negedge clk);
        vectors++;
        if (o1 !== 6'b000000) begin
            miscompares++; $display("FAIL ld1_noload got %b exp %b", o1, 6'b000000);
        end
        settle();
    endtask

    task automatic test_load_use_lat3();
        logic [5:0] exp_seq [4];
        exp_seq[0] = 6'b110100; exp_seq[1] = 6'b110101;
        exp_seq[2] = 6'b110101; exp_seq[3] = 6'b000000;
        exe_valid = 1'b1; exe_is_load = 1'b1; exe_rd = 4'h5; id_rb = 4'h5; id_use_rb = 1'b1;
        id_ra = 4'h2; id_use_ra = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (o3 !== exp_seq[i]) begin
                miscompares++; $display("FAIL ld3_c%0d got %b exp %b", i, o3, exp_seq[i]);
            end
            tick();
            exe_valid = 1'b0;
        end
        settle();
        // Match on Rb but Rb not read.
        exe_valid = 1'b1; exe_is_load = 1'b1; exe_rd = 4'h5; id_rb = 4'h5; id_use_rb = 1'b0;
        id_ra = 4'h2; id_use_ra = 1'b1;
        @(negedge clk);
        vectors++;
        if (o3 !== 6'b000000) begin
            miscompares++; $display("FAIL ld3_nouse got %b exp %b", o3, 6'b000000);
        end
        settle();
    endtask

    task automatic test_mem_wait();
        logic [5:0] exp_seq [6];
        exp_seq[0] = 6'b111000; exp_seq[1] = 6'b111001; exp_seq[2] = 6'b111001;
        exp_seq[3] = 6'b111001; exp_seq[4] = 6'b000001; exp_seq[5] = 6'b000000;
        mem_req = 1'b1; mem_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) mem_ack = 1'b1;
            if (i == 5) begin mem_req = 1'b0; mem_ack = 1'b0; end
            @(negedge clk);
            vectors++;
            if (o1 !== exp_seq[i]) begin
                miscompares++; $display("FAIL mem_c%0d got %b exp %b", i, o1, exp_seq[i]);
            end
            tick();
        end
        settle();
    endtask

    task automatic test_branch_flush();
        logic [5:0] exp_seq [3];
        exp_seq[0] = 6'b000110; exp_seq[1] = 6'b000111; exp_seq[2] = 6'b000000;
        br_taken = 1'b1;
        exe_valid = 1'b1; exe_is_load = 1'b1; exe_rd = 4'h3; id_ra = 4'h3; id_use_ra = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (o1 !== exp_seq[i]) begin
                miscompares++; $display("FAIL br_c%0d got %b exp %b", i, o1, exp_seq[i]);
            end
            tick();
            clear_inputs();
        end
        settle();
    endtask

    task automatic test_flush_mem_wait();
        logic [5:0] exp_seq [5];
        exp_seq[0] = 6'b000110; exp_seq[1] = 6'b111001; exp_seq[2] = 6'b000001;
        exp_seq[3] = 6'b000111; exp_seq[4] = 6'b000000;
        br_taken = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (o1 !== exp_seq[i]) begin
                miscompares++; $display("FAIL brmem_c%0d got %b exp %b", i, o1, exp_seq[i]);
            end
            tick();
            clear_inputs();
            if (i == 0) mem_req = 1'b1;
            if (i == 1) begin mem_req = 1'b1; mem_ack = 1'b1; end
        end
        settle();
    endtask

    task automatic test_stall_mem_wait();
        logic [5:0] exp_seq [7];
        int bubbles;
        exp_seq[0] = 6'b110100; exp_seq[1] = 6'b111001; exp_seq[2] = 6'b111001;
        exp_seq[3] = 6'b000001; exp_seq[4] = 6'b110101; exp_seq[5] = 6'b110101;
        exp_seq[6] = 6'b000000;
        bubbles = 0;
        exe_valid = 1'b1; exe_is_load = 1'b1; exe_rd = 4'h9; id_ra = 4'h9; id_use_ra = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            vectors++;
            if (o3 !== exp_seq[i]) begin
                miscompares++; $display("FAIL ldmem_c%0d got %b exp %b", i, o3, exp_seq[i]);
            end
            if (bub3 === 1'b1) bubbles++;
            tick();
            clear_inputs();
            if (i == 0 || i == 1) mem_req = 1'b1;
            if (i == 2) begin mem_req = 1'b1; mem_ack = 1'b1; end
        end
        vectors++;
        if (bubbles != 3) begin
            miscompares++; $display("FAIL ldmem_bubbles got %0d exp %0d", bubbles, 3);
        end
        settle();
    endtask

    task automatic test_reset_mid_stall();
        exe_valid = 1'b1; exe_is_load = 1'b1; exe_rd = 4'h6; id_rb = 4'h6; id_use_rb = 1'b1;
        tick();
        clear_inputs();
        @(negedge clk);
        vectors++;
        if (o3 !== 6'b110101) begin
            miscompares++; $display("FAIL rstmid_pre got %b exp %b", o3, 6'b110101);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (o3 !== 6'b000000) begin
            miscompares++; $display("FAIL rstmid_async got %b exp %b", o3, 6'b000000);
        end
        #1;
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        vectors++;
        if (o3 !== 6'b000000) begin
            miscompares++; $display("FAIL rstmid_post got %b exp %b", o3, 6'b000000);
        end
        settle();
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        exe_valid = 1'b1; exe_is_load = 1'b1; exe_rd = 4'h3; id_ra = 4'h3; id_use_ra = 1'b1;
        tick();
        clear_inputs();
        repeat (4) tick();
        br_taken = 1'b1;
        tick();
        clear_inputs();
        repeat (4) tick();
        vectors++;
        if (st3 !== 16'd3) begin
            miscompares++; $display("FAIL stats_stall got %0d exp %0d", st3, 3);
        end
        vectors++;
        if (fc3 !== 16'd2) begin
            miscompares++; $display("FAIL stats_flush got %0d exp %0d", fc3, 2);
        end
        mem_req = 1'b1;
        repeat (70000) tick();
        vectors++;
        if (st3 !== 16'hFFFF) begin
            miscompares++; $display("FAIL stats_sat got %h exp %h", st3, 16'hFFFF);
        end
        mem_ack = 1'b1;
        tick();
        settle();
    endtask
`endif

    initial begin
        test_reset();
        test_load_use_lat1();
        test_load_use_lat3();
        test_mem_wait();
        test_branch_flush();
        test_flush_mem_wait();
        test_stall_mem_wait();
        test_reset_mid_stall();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline control block on the consuming (EXE) side of the REG/EXE pipeline register.
- Reads the EXE-stage fields latched by that register and compares them with the operands of the instruction in REG.
- Drives the register's hold input (active-high EN freezes the register), the upstream PC/IF-ID holds, bubble insertion and branch flush.
- Sequences multi-cycle load-use stalls and memory-wait stalls with a small FSM and cycle counter.

Parameters:
- LOAD_LAT, 1, number of bubble cycles inserted for a load-use hazard (1..7).
- CNT_W, 3, width of the internal stall counter; must hold LOAD_LAT.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_Ra  input  4  source register A of the instruction in REG stage.
- id_Rb  input  4  source register B of the instruction in REG stage.
- id_use_Ra  input  1  REG-stage instruction reads Ra.
- id_use_Rb  input  1  REG-stage instruction reads Rb.
- exe_rd  input  4  destination register of the instruction in EXE (from the REG/EXE register).
- exe_is_load  input  1  EXE instruction is a load (decoded from o_ctrl).
- exe_valid  input  1  EXE slot holds a real instruction, not a bubble.
- br_taken  input  1  EXE resolved a taken branch this cycle.
- mem_req  input  1  MEM stage has an outstanding data-memory access.
- mem_ack  input  1  data memory completes the access this cycle.
- pc_hold  output  1  freeze the PC.
- ifid_hold  output  1  freeze the IF/ID register.
- regexe_hold  output  1  drives EN of REG/EXE; 1 = keep the current contents.
- bubble  output  1  force ctrl = 0 into REG/EXE on the next edge.
- ifid_flush  output  1  clear the IF/ID register.
- busy  output  1  FSM is not in IDLE.

Behaviour:
- States: IDLE, LDSTALL, MEMWAIT, FLUSH. Counter cnt[CNT_W-1:0].
- Reset (async, rst_n=0): state=IDLE, cnt=0. All outputs 0.
- Outputs are combinational from state, cnt and the current inputs. State and cnt are registered.
- Hazard terms:
  - hz_ld = exe_valid & exe_is_load & ((id_use_Ra & id_Ra==exe_rd) | (id_use_Rb & id_Rb==exe_rd)).
  - All 16 register indices are compared; there is no zero-register exemption.
- Priority within one cycle: mem wait > branch flush > load-use.
- IDLE:
  - mem_req & !mem_ack: pc_hold=ifid_hold=regexe_hold=1; next=MEMWAIT.
  - Else br_taken: ifid_flush=1, bubble=1; next=FLUSH. A simultaneous hz_ld is discarded because it belongs to a wrong-path instruction.
  - Else hz_ld: pc_hold=ifid_hold=1, bubble=1. If LOAD_LAT>1, next=LDSTALL with cnt=LOAD_LAT-1; else stay in IDLE.
  - Else all outputs 0.
- LDSTALL:
  - pc_hold=ifid_hold=1, bubble=1.
  - Decrement cnt; when cnt==1 on entry to the cycle, next=IDLE.
  - If mem_req & !mem_ack arrives: hold all three (regexe_hold=1, bubble=0), keep cnt, next=MEMWAIT. After the memory wait, the state returns to LDSTALL if cnt!=0.
- MEMWAIT:
  - pc_hold=ifid_hold=regexe_hold=1, bubble=0, ifid_flush=0.
  - On mem_ack: holds drop in the same cycle. next=LDSTALL if cnt!=0, else IDLE.
  - br_taken is ignored while frozen; EXE is held, so br_taken remains asserted and is reevaluated after the wait.
- FLUSH:
  - One cycle with ifid_flush=1, bubble=1 (the second wrong-path slot); next=IDLE.
  - A mem wait in this cycle takes priority: next=MEMWAIT, and the flush is re-issued on return.
- busy = (state != IDLE).
- bubble and regexe_hold are never asserted together.
- Reset mid-stall returns to IDLE immediately. The instruction in REG is then reevaluated.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined, adds outputs stall_cnt[15:0] and flush_cnt[15:0]:
  - stall_cnt increments on every cycle with pc_hold=1.
  - flush_cnt increments on every cycle with ifid_flush=1.
  - Both saturate at 16'hFFFF and reset to 0 on rst_n.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Load-use, LOAD_LAT=1: exe_valid=1, exe_is_load=1, exe_rd=4'h3, id_Ra=4'h3, id_use_Ra=1 -> exactly 1 cycle of pc_hold=ifid_hold=bubble=1, regexe_hold=0, busy=0.
- LOAD_LAT=3, same hazard (match on Rb instead) -> 3 consecutive bubble cycles, busy=1 for the last 2, then IDLE; id_use_Rb=0 with a match -> no stall.
- mem_req=1, mem_ack held low for 4 cycles, then pulsed -> regexe_hold=pc_hold=ifid_hold=1 for 4 cycles, all drop in the ack cycle, bubble=0 throughout.
- br_taken=1 together with hz_ld=1 -> 2 cycles ifid_flush=bubble=1, no pc_hold; then IDLE.
- LOAD_LAT=3: mem wait beginning in the 2nd stall cycle -> freeze until ack, then the remaining bubble cycle completes (3 bubbles total); rst_n low mid-stall -> all outputs 0 asynchronously.
- HAZARD_STATS_EN: 3-cycle load stall plus 1 branch -> stall_cnt=3, flush_cnt=2; forced 70000 hold cycles -> stall_cnt=16'hFFFF.
